mem_access_arbiter: RTL
=======================

// Module: mem_access_arbiter
// PURPOSE
// - Shares the single RAM port between instruction-fetch and data-access requesters.
// - Takes registered enables/addresses from the request unit. Grants one access at a time,
//   waits on RAM handshake, returns one-cycle ihit/dhit with load data.
// - Data has priority; a streak counter bounds instruction starvation; a watchdog flags a hung RAM.
// PARAMETERS
// - TIMEOUT      16  max cycles a grant may wait for ACCESS before entering ERR (>=2)
// - MAX_DSTREAK  4   consecutive data grants allowed while iREN pending before fetch is forced (>=1)
// PORTS
// - CLK       in   1   clock, rising edge
// - nRST      in   1   async active-low reset
// - iREN      in   1   instruction read request (level, held until ihit)
// - iaddr     in   32  instruction address (word_t)
// - dREN      in   1   data read request
// - dWEN      in   1   data write request
// - daddr     in   32  data address
// - dstore    in   32  data write value
// - ihit      out  1   one-cycle pulse: instruction access complete
// - iload     out  32  fetched instruction, valid while ihit=1
// - dhit      out  1   one-cycle pulse: data access complete
// - dload     out  32  read data, valid while dhit=1 after a read
// - ramREN    out  1   RAM read enable
// - ramWEN    out  1   RAM write enable
// - ramaddr   out  32  RAM address
// - ramstore  out  32  RAM write data
// - ramload   in   32  RAM read data, valid when ramstate==ACCESS
// - ramstate  in   2   ramstate_t {FREE, BUSY, ACCESS, ERROR}
// - arb_err   out  1   sticky: RAM reported ERROR or watchdog expired
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 (loads, ram*, hits, arb_err); timer=0, streak=0.
// - Reset is honoured mid-access. Enables drop asynchronously; in-flight access is abandoned.
// - States: IDLE, IGRANT, DGRANT, DONE, ERR. All RAM outputs are driven from latched regs only.
// - IDLE: ram enables 0. Arbitrate on sampled inputs:
//   - (dREN|dWEN) && !(iREN && streak==MAX_DSTREAK): latch daddr/dstore/op, go DGRANT.
//     streak <= iREN ? streak+1 : 0.
//   - else if iREN: latch iaddr, go IGRANT, streak <= 0.
//   - else: stay IDLE, streak <= 0.
//   - dREN&dWEN together: treated as write (ramWEN=1, ramREN=0).
// - IGRANT/DGRANT: ramaddr=latched addr; IGRANT ramREN=1.
//   - DGRANT: ramREN=op_rd, ramWEN=op_wr, ramstore=latched dstore.
//   - ramstate==ACCESS: capture ramload into load reg (reads), go DONE, timer<=0.
//   - ramstate==ERROR: go ERR.
//   - FREE/BUSY: timer++. When timer==TIMEOUT-1 and still not ACCESS, go ERR.
// - DONE (exactly 1 cycle): ram enables 0.
//   - ihit=1 (from IGRANT) or dhit=1 (from DGRANT), never both.
//   - iload/dload present the captured word. Inputs are ignored this cycle. Next IDLE.
// - Latency: request seen in IDLE at cycle n, RAM ACCESS at cycle n+k (k>=1), hit at cycle n+k+1.
//   Minimum 3 cycles per access.
// - iload/dload hold their last value outside DONE. The dload write path is unchanged.
// - ERR: ram enables 0, hits 0, arb_err=1. Exits only on nRST.
// - Requests dropped while granted do not cancel the access; the hit still pulses once.
// - Addresses/data changing during a grant have no effect (latched values used).
// STRUCTURE
// - cpu_types_pkg: ramstate_t (existing), word_t, new arb_state_t enum.
// - cpu_types_pkg: constant ARB_TIMER_W = $clog2(TIMEOUT) computed locally.
// - One sub-module: arb_watchdog. Timer with clear/enable inputs and expired output,
//   parameter TIMEOUT.
// - Streak counter and FSM are local to mem_access_arbiter.
// TESTING
// - Reset mid-grant: assert nRST=0 during DGRANT write -> ramWEN=0 same cycle, state IDLE,
//   arb_err=0, no dhit.
// - Lone fetch: iREN=1 iaddr=0x100, RAM ACCESS after 2 BUSY, ramload=0x8C220004
//   -> ramREN=1 for 3 cycles, ihit one cycle later with iload=0x8C220004.
// - Data priority: iREN=1 and dREN=1 daddr=0x200 in same IDLE -> data granted first, dhit
//   precedes ihit. Then fetch granted next IDLE.
// - Starvation bound (MAX_DSTREAK=4): iREN held, dWEN held continuously
//   -> 4 dhits, then 1 ihit, pattern repeats.
// - Watchdog (TIMEOUT=16): ramstate stuck BUSY after grant -> ERR at 16th grant cycle.
//   arb_err=1, enables 0, no hit, persists until nRST.
// - RAM ERROR / double enable: ramstate=ERROR -> arb_err next cycle.
//   dREN=dWEN=1 -> ramWEN=1, ramREN=0, ramstore=dstore.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, word type and arbiter FSM states.
// Also holds the default arbiter timing constants.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE,
    IGRANT,
    DGRANT,
    DONE,
    ERR
  } arb_state_t;

  localparam int ARB_TIMEOUT = 16;
  localparam int ARB_TIMER_W = $clog2(ARB_TIMEOUT);

endpackage

// File: rtl/mem_access_arbiter_watchdog.sv
// Grant watchdog: counts stalled grant cycles and flags
// when the RAM has kept a grant waiting too long.
module arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] timer;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (en && !expired) begin
      timer <= timer + 1'b1;
    end
  end

  assign expired = (timer == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_arbiter.sv
// Single-port RAM arbiter between fetch and data requesters.
// Data wins unless fetch has waited MAX_DSTREAK data grants.
module mem_access_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT     = 16,
  parameter int MAX_DSTREAK = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      ihit,
  output word_t     iload,
  output logic      dhit,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      arb_err
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);

  arb_state_t    state, nxt;
  word_t         addr_r, store_r;
  word_t         iload_r, dload_r;
  logic          op_rd, op_wr, is_d;
  logic [SW-1:0] streak;

  logic granted, acc, stall;
  logic d_req, starve, d_win;
  logic wd_clear, wd_en, expired;

  assign granted = (state == IGRANT) ||
                   (state == DGRANT);
  assign acc     = (ramstate == ACCESS);
  assign stall   = (ramstate == FREE) ||
                   (ramstate == BUSY);

  assign d_req  = dREN | dWEN;
  assign starve = iREN &&
                  (streak == SW'(MAX_DSTREAK));
  assign d_win  = d_req && !starve;

  assign wd_clear = !granted || acc;
  assign wd_en    = granted && stall;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .CLK    (CLK),
    .nRST   (nRST),
    .clear  (wd_clear),
    .en     (wd_en),
    .expired(expired)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (d_win) begin
          nxt = DGRANT;
        end else if (iREN) begin
          nxt = IGRANT;
        end
      end
      IGRANT, DGRANT: begin
        if (acc) begin
          nxt = DONE;
        end else if (ramstate == ERROR) begin
          nxt = ERR;
        end else if (expired) begin
          nxt = ERR;
        end
      end
      DONE:    nxt = IDLE;
      ERR:     nxt = ERR;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      addr_r  <= '0;
      store_r <= '0;
      iload_r <= '0;
      dload_r <= '0;
      op_rd   <= 1'b0;
      op_wr   <= 1'b0;
      is_d    <= 1'b0;
      streak  <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE) begin
        if (d_win) begin
          addr_r  <= daddr;
          store_r <= dstore;
          op_wr   <= dWEN;
          op_rd   <= dREN & ~dWEN;
          is_d    <= 1'b1;
          streak  <= iREN ? streak + 1'b1 : '0;
        end else if (iREN) begin
          addr_r <= iaddr;
          op_wr  <= 1'b0;
          op_rd  <= 1'b0;
          is_d   <= 1'b0;
          streak <= '0;
        end else begin
          streak <= '0;
        end
      end
      if (granted && acc) begin
        if (!is_d) begin
          iload_r <= ramload;
        end else if (op_rd) begin
          dload_r <= ramload;
        end
      end
    end
  end

  assign ramREN = (state == IGRANT) ||
                  ((state == DGRANT) && op_rd);
  assign ramWEN = (state == DGRANT) && op_wr;

  assign ramaddr  = addr_r;
  assign ramstore = store_r;

  assign ihit    = (state == DONE) && !is_d;
  assign dhit    = (state == DONE) && is_d;
  assign iload   = iload_r;
  assign dload   = dload_r;
  assign arb_err = (state == ERR);

endmodule
